mobo_bus_arbiter: RTL and testbench
===================================

MOBO_BUS_ARBITER -- requirements
Module: mobo_bus_arbiter

Interface
REQ-001 Parameters SHALL be: WORD_WIDTH, 32, data/address width; ACK_TIMEOUT, 255, maximum WAIT_ACK cycles before error.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on posedge.
- rst, in, 1, synchronous active-high reset.
- req0_ctrl, in, 2, requester 0 command: bit0 write, bit1 read.
- req0_addr, in, WORD_WIDTH, requester 0 address.
- req0_wdata, in, WORD_WIDTH, requester 0 write data.
- req0_stat, out, 2, requester 0 status: bit0 done, bit1 error.
- req0_rdata, out, WORD_WIDTH, requester 0 read data.
- req1_ctrl, req1_addr, req1_wdata, req1_stat, req1_rdata: same as requester 0, for requester 1.
- dev_ctrl, out, 2, device command: bit0 write, bit1 read.
- dev_stat, in, 1, device ACK.
- dev_addr, out, WORD_WIDTH, device address.
- dev_wdata, out, WORD_WIDTH, device write data.
- dev_rdata, in, WORD_WIDTH, device read data.
REQ-003 Reset SHALL be synchronous, active-high, on port rst, sampled on posedge clk.

Function
REQ-004 Outputs SHALL be registered.
REQ-005 States SHALL be IDLE, WAIT_ACK, WAIT_DROP, DONE.
REQ-006 IDLE: if dev_stat=0 and any reqN_ctrl!=0, the arbiter SHALL grant one requester, latch its addr, wdata and ctrl, and go to WAIT_ACK.
- If dev_stat=1, no grant SHALL occur.
REQ-007 Arbitration SHALL be round-robin.
- With both requesting, grant goes to the requester not granted last.
- Last-grant pointer resets to 1, so requester 0 wins the first tie.
- Pointer updates on DONE->IDLE.
REQ-008 Granted ctrl=2'b11 (both bits) SHALL skip the device, set error, and go directly to DONE.
REQ-009 WAIT_ACK: dev_ctrl SHALL equal the latched ctrl; dev_addr and dev_wdata SHALL hold latched values.
- Latency: request sampled in IDLE at edge N -> dev_ctrl valid after edge N+1.
REQ-010 WAIT_ACK with dev_stat=1 SHALL go to WAIT_DROP.
- dev_ctrl cleared to 0.
- For reads, dev_rdata latched into the granted requester's reqN_rdata.
REQ-011 A timeout counter SHALL clear on entry to WAIT_ACK and increment each WAIT_ACK cycle.
- At count = ACK_TIMEOUT with no ACK: clear dev_ctrl, set error, go to WAIT_DROP.
REQ-012 WAIT_DROP SHALL stay until dev_stat=0, then go to DONE.
REQ-013 DONE: the granted requester's reqN_stat bit0 SHALL be 1, and bit1 SHALL be 1 if an error occurred.
- Stay in DONE while its reqN_ctrl!=0.
- When reqN_ctrl=0: clear its stat to 0 and go to IDLE.
REQ-014 The non-granted requester's stat SHALL stay 0; its pending request SHALL be held off, not dropped.
REQ-015 reqN_rdata SHALL hold its value until the next read granted to that requester.
REQ-016 A requester changing addr, wdata or ctrl after grant SHALL NOT affect the transaction in flight.
REQ-017 Writes SHALL leave reqN_rdata unchanged.

Reset
REQ-018 On rst=1 at a posedge, the following SHALL clear:
- state -> IDLE.
- dev_ctrl, dev_addr, dev_wdata, req0_stat, req1_stat, req0_rdata, req1_rdata -> 0.
- timeout counter -> 0; last-grant pointer -> 1.
REQ-019 Reset mid-transaction SHALL abort it in one cycle (dev_ctrl=0 after the edge), with no done or error reported.
REQ-020 rst SHALL take priority over all state transitions.

Verification
REQ-021 Single read: req0_ctrl=2'b10, addr=0x10; device ACKs 3 cycles after dev_ctrl with rdata=0xCAFE0001.
- Required: req0_rdata=0xCAFE0001, req0_stat=2'b01.
- After req0_ctrl=0, stat returns to 0 and state to IDLE.
REQ-022 Contention: req0 and req1 both write in the same cycle from reset.
- Required: req0 is served first, req1 second.
- Repeating the contention: req1 is served first.
REQ-023 Timeout: req1 reads, device never ACKs.
- Required: dev_ctrl drops after 255 WAIT_ACK cycles, and req1_stat=2'b11.
REQ-024 Illegal command: req0_ctrl=2'b11.
- Required: dev_ctrl stays 0, and req0_stat=2'b11.
REQ-025 Reset mid-transaction: assert rst during WAIT_ACK of a req0 write.
- Required: next cycle dev_ctrl=0 and req0_stat=0; a later req1 read completes normally.
REQ-026 Stale ACK: dev_stat held 1 while req0 requests.
- Required: no grant until dev_stat=0; the grant follows on the next cycle.

Source files
------------

// File: rtl/mobo_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single ACK-handshaked device.
// One transaction at a time: grant, drive the device, wait for ACK drop, report done/error.
module mobo_bus_arbiter #(
    parameter int WORD_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req0_ctrl,
    input  logic [WORD_WIDTH-1:0] req0_addr,
    input  logic [WORD_WIDTH-1:0] req0_wdata,
    output logic [1:0]            req0_stat,
    output logic [WORD_WIDTH-1:0] req0_rdata,
    input  logic [1:0]            req1_ctrl,
    input  logic [WORD_WIDTH-1:0] req1_addr,
    input  logic [WORD_WIDTH-1:0] req1_wdata,
    output logic [1:0]            req1_stat,
    output logic [WORD_WIDTH-1:0] req1_rdata,
    output logic [1:0]            dev_ctrl,
    input  logic                  dev_stat,
    output logic [WORD_WIDTH-1:0] dev_addr,
    output logic [WORD_WIDTH-1:0] dev_wdata,
    input  logic [WORD_WIDTH-1:0] dev_rdata
);

    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DROP, DONE} state_t;

    state_t           state;
    logic             grant;       // requester owning the current transaction
    logic             last_grant;  // requester served most recently
    logic             err;
    logic [1:0]       lat_ctrl;
    logic [CNT_W-1:0] timer;

    logic       req0_act, req1_act, pick;
    logic [1:0] pick_ctrl, owner_ctrl;

    assign req0_act = |req0_ctrl;
    assign req1_act = |req1_ctrl;

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        pick = req1_act;
        if (req0_act && req1_act) pick = ~last_grant;
    end

    assign pick_ctrl  = pick  ? req1_ctrl : req0_ctrl;
    assign owner_ctrl = grant ? req1_ctrl : req0_ctrl;

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            err        <= 1'b0;
            lat_ctrl   <= 2'b00;
            timer      <= '0;
            dev_ctrl   <= 2'b00;
            dev_addr   <= '0;
            dev_wdata  <= '0;
            req0_stat  <= 2'b00;
            req1_stat  <= 2'b00;
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A still-high ACK belongs to a previous cycle; wait it out before granting.
                    if (!dev_stat && (req0_act || req1_act)) begin
                        grant     <= pick;
                        lat_ctrl  <= pick_ctrl;
                        dev_addr  <= pick ? req1_addr  : req0_addr;
                        dev_wdata <= pick ? req1_wdata : req0_wdata;
                        timer     <= '0;
                        if (pick_ctrl == 2'b11) begin
                            err   <= 1'b1;
                            state <= DONE;
                            if (pick) req1_stat <= 2'b11;
                            else      req0_stat <= 2'b11;
                        end else begin
                            err   <= 1'b0;
                            state <= WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (dev_stat) begin
                        dev_ctrl <= 2'b00;
                        state    <= WAIT_DROP;
                        if (lat_ctrl[1]) begin
                            if (grant) req1_rdata <= dev_rdata;
                            else       req0_rdata <= dev_rdata;
                        end
                    end else if (timer == CNT_W'(ACK_TIMEOUT)) begin
                        dev_ctrl <= 2'b00;
                        err      <= 1'b1;
                        state    <= WAIT_DROP;
                    end else begin
                        dev_ctrl <= lat_ctrl;
                        timer    <= timer + 1'b1;
                    end
                end
                WAIT_DROP: begin
                    if (!dev_stat) begin
                        state <= DONE;
                        if (grant) req1_stat <= {err, 1'b1};
                        else       req0_stat <= {err, 1'b1};
                    end
                end
                DONE: begin
                    if (owner_ctrl == 2'b00) begin
                        req0_stat  <= 2'b00;
                        req1_stat  <= 2'b00;
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mobo_bus_arbiter.sv
// Bench for mobo_bus_arbiter: directed scenarios plus randomized rounds checked against
// a transaction-level round-robin model and a behavioural device responder.
module tb_mobo_bus_arbiter;

    localparam int W   = 32;
    localparam int TMO = 255;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   rq_ctrl  [2];
    logic [W-1:0] rq_addr  [2];
    logic [W-1:0] rq_wdata [2];
    logic [1:0]   rq_stat  [2];
    logic [W-1:0] rq_rdata [2];
    logic [1:0]   dev_ctrl;
    logic         dev_stat;
    logic [W-1:0] dev_addr, dev_wdata, dev_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [1:0]   ctrl;
        logic [W-1:0] rdata;
    } bus_rec_t;

    bus_rec_t     bus_log[$];      // every transaction the device acknowledged
    int           served[$];       // completion order of requesters
    logic [W-1:0] exp_rdata [2];
    int           last_model;

    int           ack_delay   = 0;
    bit           never_ack   = 0;
    bit           dev_manual  = 0;
    logic         manual_stat = 1'b0;
    bit           fixed_en    = 0;
    logic [W-1:0] fixed_rdata = '0;

    always #5 clk = ~clk;

    mobo_bus_arbiter #(.WORD_WIDTH(W), .ACK_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_ctrl  (rq_ctrl[0]),
        .req0_addr  (rq_addr[0]),
        .req0_wdata (rq_wdata[0]),
        .req0_stat  (rq_stat[0]),
        .req0_rdata (rq_rdata[0]),
        .req1_ctrl  (rq_ctrl[1]),
        .req1_addr  (rq_addr[1]),
        .req1_wdata (rq_wdata[1]),
        .req1_stat  (rq_stat[1]),
        .req1_rdata (rq_rdata[1]),
        .dev_ctrl   (dev_ctrl),
        .dev_stat   (dev_stat),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_rdata  (dev_rdata)
    );

    // Device: ACKs ack_delay cycles after seeing a command, holds ACK until the command drops.
    initial begin : responder
        int       wait_cnt;
        bit       acked;
        bus_rec_t rec;
        wait_cnt  = 0;
        acked     = 0;
        dev_stat  = 1'b0;
        dev_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b1) begin
                dev_stat = 1'b0;
                acked    = 0;
                wait_cnt = 0;
            end else if (dev_manual) begin
                dev_stat = manual_stat;
            end else if (acked) begin
                if (dev_ctrl == 2'b00) begin
                    dev_stat = 1'b0;
                    acked    = 0;
                    wait_cnt = 0;
                end
            end else if (dev_ctrl != 2'b00 && !never_ack) begin
                if (wait_cnt >= ack_delay) begin
                    dev_rdata = fixed_en ? fixed_rdata : W'($urandom);
                    dev_stat  = 1'b1;
                    acked     = 1;
                    rec.addr  = dev_addr;
                    rec.wdata = dev_wdata;
                    rec.ctrl  = dev_ctrl;
                    rec.rdata = dev_rdata;
                    bus_log.push_back(rec);
                end else begin
                    wait_cnt++;
                end
            end else if (dev_ctrl == 2'b00) begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst        = 1'b1;
        dev_manual = 0;
        never_ack  = 0;
        for (int n = 0; n < 2; n++) begin
            rq_ctrl[n]   = 2'b00;
            rq_addr[n]   = '0;
            rq_wdata[n]  = '0;
            exp_rdata[n] = '0;
        end
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        last_model = 1;
    endtask

    task automatic start_req(input int n, input logic [1:0] c, input logic [W-1:0] a,
                             input logic [W-1:0] d);
        rq_ctrl[n]  = c;
        rq_addr[n]  = a;
        rq_wdata[n] = d;
    endtask

    // Waits for done, checks status/bus/read data, releases the request and checks stat clears.
    task automatic finish_req(input int n, input logic [1:0] c, input logic [W-1:0] a,
                              input logic [W-1:0] d);
        logic [1:0] exp_stat;
        bit         done;
        bus_rec_t   rec;
        exp_stat = (c == 2'b11) ? 2'b11 : 2'b01;
        done     = 0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk);
            if (rq_stat[n][0] === 1'b1) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_req%0d: stat=%b never showed done, expected %b", n, rq_stat[n], exp_stat);
        end else begin
            served.push_back(n);
            checks++;
            if (rq_stat[n] !== exp_stat) begin
                errors++;
                $display("FAIL stat_req%0d: got %b expected %b", n, rq_stat[n], exp_stat);
            end
            if (c != 2'b11) begin
                checks++;
                if (bus_log.size() == 0) begin
                    errors++;
                    $display("FAIL bus_req%0d: device log empty, expected addr=%h", n, a);
                end else begin
                    rec = bus_log[$];
                    if (rec.addr !== a || rec.wdata !== d || rec.ctrl !== c) begin
                        errors++;
                        $display("FAIL bus_req%0d: got addr=%h wdata=%h ctrl=%b expected addr=%h wdata=%h ctrl=%b",
                                 n, rec.addr, rec.wdata, rec.ctrl, a, d, c);
                    end
                    if (c == 2'b10) exp_rdata[n] = rec.rdata;
                end
            end
            checks++;
            if (rq_rdata[n] !== exp_rdata[n]) begin
                errors++;
                $display("FAIL rdata_req%0d: got %h expected %h", n, rq_rdata[n], exp_rdata[n]);
            end
        end
        rq_ctrl[n] = 2'b00;
        @(negedge clk);
        checks++;
        if (rq_stat[n] !== 2'b00) begin
            errors++;
            $display("FAIL stat_clear_req%0d: got %b expected 00", n, rq_stat[n]);
        end
        last_model = n;
    endtask

    task automatic run_req(input int n, input logic [1:0] c, input logic [W-1:0] a,
                           input logic [W-1:0] d);
        start_req(n, c, a, d);
        finish_req(n, c, a, d);
    endtask

    task automatic wait_bus_busy(input string tag);
        for (int i = 0; i < 10 && dev_ctrl == 2'b00; i++) @(negedge clk);
        checks++;
        if (dev_ctrl == 2'b00) begin
            errors++;
            $display("FAIL %s: dev_ctrl=%b never asserted, expected nonzero", tag, dev_ctrl);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (dev_ctrl !== 2'b00)   begin errors++; $display("FAIL rst_dev_ctrl: got %b expected 00", dev_ctrl); end
        if (dev_addr !== '0)      begin errors++; $display("FAIL rst_dev_addr: got %h expected 0", dev_addr); end
        if (dev_wdata !== '0)     begin errors++; $display("FAIL rst_dev_wdata: got %h expected 0", dev_wdata); end
        if (rq_stat[0] !== 2'b00) begin errors++; $display("FAIL rst_stat0: got %b expected 00", rq_stat[0]); end
        if (rq_stat[1] !== 2'b00) begin errors++; $display("FAIL rst_stat1: got %b expected 00", rq_stat[1]); end
        if (rq_rdata[0] !== '0)   begin errors++; $display("FAIL rst_rdata0: got %h expected 0", rq_rdata[0]); end
        if (rq_rdata[1] !== '0)   begin errors++; $display("FAIL rst_rdata1: got %h expected 0", rq_rdata[1]); end
    endtask

    task automatic test_single_read();
        ack_delay   = 3;
        fixed_en    = 1;
        fixed_rdata = 32'hCAFE_0001;
        run_req(0, 2'b10, 32'h10, 32'h1234_5678);
        fixed_en = 0;
        checks++;
        if (rq_rdata[0] !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL single_read_rdata: got %h expected cafe0001", rq_rdata[0]);
        end
    endtask

    task automatic test_reset_mid_transaction();
        never_ack = 1;
        start_req(0, 2'b01, 32'hA0, 32'h0BAD_F00D);
        wait_bus_busy("rst_mid_busy");
        rst        = 1'b1;
        rq_ctrl[0] = 2'b00;
        @(negedge clk);
        checks += 3;
        if (dev_ctrl !== 2'b00)   begin errors++; $display("FAIL rst_mid_dev_ctrl: got %b expected 00", dev_ctrl); end
        if (rq_stat[0] !== 2'b00) begin errors++; $display("FAIL rst_mid_stat0: got %b expected 00", rq_stat[0]); end
        if (rq_rdata[0] !== '0)   begin errors++; $display("FAIL rst_mid_rdata0: got %h expected 0", rq_rdata[0]); end
        rst          = 1'b0;
        never_ack    = 0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        last_model   = 1;
        ack_delay    = 1;
        run_req(1, 2'b10, 32'hB0, 32'h0);
    endtask

    task automatic test_contention();
        do_reset();
        served.delete();
        ack_delay = 2;
        fork
            begin
                run_req(0, 2'b01, 32'h100, 32'h1111_0000);
                run_req(0, 2'b01, 32'h104, 32'h1111_0001);
            end
            run_req(1, 2'b01, 32'h200, 32'h2222_0000);
        join
        checks++;
        if (served.size() != 3 || served[0] != 0 || served[1] != 1 || served[2] != 0) begin
            errors++;
            $display("FAIL contention_order: got %p expected '{0, 1, 0}", served);
        end
    endtask

    task automatic test_in_flight_change();
        ack_delay = 4;
        start_req(0, 2'b01, 32'h300, 32'h3333_3333);
        wait_bus_busy("inflight_busy");
        rq_addr[0]  = 32'hFFFF_0300;
        rq_wdata[0] = 32'hCCCC_CCCC;
        rq_ctrl[0]  = 2'b10;
        repeat (2) @(negedge clk);
        checks++;
        if (dev_addr !== 32'h300 || dev_wdata !== 32'h3333_3333 || dev_ctrl !== 2'b01) begin
            errors++;
            $display("FAIL inflight_hold: got addr=%h wdata=%h ctrl=%b expected addr=300 wdata=33333333 ctrl=01",
                     dev_addr, dev_wdata, dev_ctrl);
        end
        finish_req(0, 2'b01, 32'h300, 32'h3333_3333);
    endtask

    task automatic test_illegal();
        bit saw_bus;
        int log_before;
        saw_bus    = 0;
        log_before = bus_log.size();
        fork
            run_req(0, 2'b11, 32'h400, 32'h4444_4444);
            repeat (8) begin
                @(negedge clk);
                if (dev_ctrl !== 2'b00) saw_bus = 1;
            end
        join
        checks++;
        if (saw_bus || bus_log.size() != log_before) begin
            errors++;
            $display("FAIL illegal_no_bus: device saw a command (log %0d -> %0d), expected none",
                     log_before, bus_log.size());
        end
    endtask

    task automatic test_stale_ack();
        bit early;
        early       = 0;
        ack_delay   = 1;
        dev_manual  = 1;
        manual_stat = 1'b1;
        start_req(0, 2'b10, 32'h5A5A, 32'h0);
        repeat (5) begin
            @(negedge clk);
            if (dev_ctrl !== 2'b00 || dev_addr === 32'h5A5A) early = 1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL stale_no_grant: dev_ctrl=%b dev_addr=%h while ACK held, expected no grant", dev_ctrl, dev_addr);
        end
        manual_stat = 1'b0;
        @(negedge clk);
        checks++;
        if (dev_addr !== 32'h5A5A || dev_ctrl !== 2'b00) begin
            errors++;
            $display("FAIL stale_grant_edge: got addr=%h ctrl=%b expected addr=5a5a ctrl=00", dev_addr, dev_ctrl);
        end
        @(negedge clk);
        checks++;
        if (dev_ctrl !== 2'b10) begin
            errors++;
            $display("FAIL stale_dev_ctrl: got %b expected 10", dev_ctrl);
        end
        dev_manual = 0;
        finish_req(0, 2'b10, 32'h5A5A, 32'h0);
    endtask

    task automatic test_timeout();
        int hi;
        bit done;
        hi        = 0;
        done      = 0;
        never_ack = 1;
        start_req(1, 2'b10, 32'h600, 32'h0);
        wait_bus_busy("timeout_busy");
        while (dev_ctrl != 2'b00 && hi < 400) begin
            hi++;
            @(negedge clk);
        end
        checks++;
        if (hi != TMO) begin
            errors++;
            $display("FAIL timeout_len: dev_ctrl high %0d cycles expected %0d", hi, TMO);
        end
        for (int i = 0; i < 10 && !done; i++) begin
            if (rq_stat[1][0] === 1'b1) done = 1;
            else @(negedge clk);
        end
        checks += 2;
        if (rq_stat[1] !== 2'b11) begin
            errors++;
            $display("FAIL timeout_stat: got %b expected 11", rq_stat[1]);
        end
        if (rq_rdata[1] !== exp_rdata[1]) begin
            errors++;
            $display("FAIL timeout_rdata: got %h expected %h", rq_rdata[1], exp_rdata[1]);
        end
        rq_ctrl[1] = 2'b00;
        never_ack  = 0;
        @(negedge clk);
        checks++;
        if (rq_stat[1] !== 2'b00) begin
            errors++;
            $display("FAIL timeout_clear: got %b expected 00", rq_stat[1]);
        end
        last_model = 1;
    endtask

    function automatic logic [1:0] pick_ctrl();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 2'b00;
        if (r == 1) return 2'b11;
        if (r < 6)  return 2'b01;
        return 2'b10;
    endfunction

    task automatic test_random(input int rounds);
        logic [1:0]   c0, c1;
        logic [W-1:0] a0, a1, d0, d1;
        int           exp_order[$];
        for (int r = 0; r < rounds; r++) begin
            c0 = pick_ctrl();
            c1 = pick_ctrl();
            if (c0 == 2'b00 && c1 == 2'b00) c0 = 2'b01;
            a0 = W'($urandom);
            a1 = W'($urandom);
            d0 = W'($urandom);
            d1 = W'($urandom);
            ack_delay = $urandom_range(0, 4);
            exp_order.delete();
            if (c0 != 2'b00 && c1 != 2'b00) begin
                exp_order.push_back(1 - last_model);
                exp_order.push_back(last_model);
            end else begin
                exp_order.push_back((c0 != 2'b00) ? 0 : 1);
            end
            served.delete();
            fork
                if (c0 != 2'b00) run_req(0, c0, a0, d0);
                if (c1 != 2'b00) run_req(1, c1, a1, d1);
            join
            checks++;
            if (served != exp_order) begin
                errors++;
                $display("FAIL rand_order[%0d]: got %p expected %p (ctrl0=%b ctrl1=%b)", r, served, exp_order, c0, c1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_reset_mid_transaction();
        test_contention();
        test_in_flight_change();
        test_illegal();
        test_stale_ack();
        test_timeout();
        test_random(24);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
